// File: rtl/branch_predictor_pkg.sv
// Shared pipeline package for the fetch-stage branch predictor.
// Holds the table geometry, the 2-bit counter encoding, the table entry
// layout, the counter reset value and the entry training function.
package branch_predictor_pkg;

    localparam int unsigned BP_PC_WIDTH   = 32;
    localparam int unsigned BP_INDEX_BITS = 6;
    localparam int unsigned BP_TAG_BITS   = BP_PC_WIDTH - BP_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_counter_t;

    localparam bp_counter_t BP_CTR_RESET = WNT;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        bp_counter_t            counter;
        logic [BP_PC_WIDTH-1:0] target;
    } bp_entry_t;

    // Next value of an entry after a resolved branch.
    // A taken branch that misses (invalid or foreign tag) installs at WT:
    // invalid entries always hold WNT, so this equals a +1 from reset.
    // A not-taken branch only trains an entry that already belongs to it.
    function automatic bp_entry_t bp_train(
        input bp_entry_t              old,
        input logic [BP_TAG_BITS-1:0] tag,
        input logic                   taken,
        input logic [BP_PC_WIDTH-1:0] target
    );
        bp_entry_t nxt;
        logic      hit;
        nxt = old;
        hit = old.valid && (old.tag == tag);
        if (taken) begin
            nxt.valid  = 1'b1;
            nxt.tag    = tag;
            nxt.target = target;
            if (!hit) begin
                nxt.counter = WT;
            end else if (old.counter != ST) begin
                nxt.counter = bp_counter_t'(old.counter + 2'd1);
            end
        end else if (hit && (old.counter != SNT)) begin
            nxt.counter = bp_counter_t'(old.counter - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> branch predictor signal bundle.
// master: pipeline/hazard side (drives fetch PC, decode-stage branch info,
//         stall/flush; receives prediction, miss flag and redirect PC).
// slave : branch predictor.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int unsigned PC_WIDTH = BP_PC_WIDTH
);
    logic [PC_WIDTH-1:0] pc_f;
    logic                stall_f;
    logic                stall_d;
    logic                flush_d;
    logic [1:0]          branch_d;
    logic                pc_src_d;
    logic [PC_WIDTH-1:0] pc_branch_d;
    logic [PC_WIDTH-1:0] pc_plus4_d;
    logic [PC_WIDTH-1:0] pc_pred_f;
    logic                predict_miss;
    logic [PC_WIDTH-1:0] pc_correct_d;

    modport master (
        output pc_f, stall_f, stall_d, flush_d, branch_d,
               pc_src_d, pc_branch_d, pc_plus4_d,
        input  pc_pred_f, predict_miss, pc_correct_d
    );

    modport slave (
        input  pc_f, stall_f, stall_d, flush_d, branch_d,
               pc_src_d, pc_branch_d, pc_plus4_d,
        output pc_pred_f, predict_miss, pc_correct_d
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Branch target buffer: direct-mapped table of {valid, tag, counter, target}.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears valid, counters)
//   rd_index / rd_entry async read port used by the fetch lookup
//   wr_en, wr_index,    sync training port: on wr_en the entry at wr_index
//   wr_tag, wr_taken,   is updated with the resolved branch outcome
//   wr_target
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = BP_INDEX_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  rd_index,
    output bp_entry_t              rd_entry,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [BP_TAG_BITS-1:0] wr_tag,
    input  logic                   wr_taken,
    input  logic [BP_PC_WIDTH-1:0] wr_target
);
    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    // Only valid and counter bits are reset; tag/target are don't-care
    // while the entry is invalid.
    logic                   valid_q  [ENTRIES];
    bp_counter_t            ctr_q    [ENTRIES];
    logic [BP_TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [BP_PC_WIDTH-1:0] target_q [ENTRIES];

    bp_entry_t wr_old;
    bp_entry_t wr_new;

    always_comb begin
        rd_entry         = '0;
        rd_entry.valid   = valid_q[rd_index];
        rd_entry.tag     = tag_q[rd_index];
        rd_entry.counter = ctr_q[rd_index];
        rd_entry.target  = target_q[rd_index];
    end

    // Training is a read-modify-write of the entry at wr_index.
    always_comb begin
        wr_old         = '0;
        wr_old.valid   = valid_q[wr_index];
        wr_old.tag     = tag_q[wr_index];
        wr_old.counter = ctr_q[wr_index];
        wr_old.target  = target_q[wr_index];
        wr_new         = bp_train(wr_old, wr_tag, wr_taken, wr_target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_CTR_RESET;
            end
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_new.valid;
            ctr_q[wr_index]   <= wr_new.counter;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]    <= wr_new.tag;
            target_q[wr_index] <= wr_new.target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bp     slave side of branch_predictor_if:
//            in : pc_f, stall_f, stall_d, flush_d, branch_d, pc_src_d,
//                 pc_branch_d, pc_plus4_d
//            out: pc_pred_f (predicted next fetch PC, combinational),
//                 predict_miss / pc_correct_d (Decode-stage redirect)
// The prediction made in Fetch travels with the instruction into Decode,
// where it is compared with the resolved branch and the table is trained.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = BP_INDEX_BITS,
    parameter int unsigned PC_WIDTH   = BP_PC_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned TAG_LSB = INDEX_BITS + 2;

    bp_entry_t             rd_entry;
    logic                  hit_f;
    logic                  pred_taken_f;
    logic [INDEX_BITS-1:0] index_f;

    logic                  rec_valid_q;
    logic [INDEX_BITS-1:0] rec_index_q;
    logic                  rec_pred_taken_q;
    logic [PC_WIDTH-1:0]   rec_pred_target_q;

    logic                  resolve_d;
    logic [PC_WIDTH-1:0]   pc_d;

    // Fetch stall needs no handling here: the F/D record is governed by
    // stall_d, which the hazard unit always raises alongside stall_f.
    logic                  unused_stall_f;
    logic [TAG_LSB-1:0]    unused_pc_d_lo;

    assign unused_stall_f = bp.stall_f;

    // ---------------- Fetch lookup ----------------
    assign index_f      = bp.pc_f[TAG_LSB-1:2];
    assign hit_f        = rd_entry.valid && (rd_entry.tag == bp.pc_f[PC_WIDTH-1:TAG_LSB]);
    assign pred_taken_f = hit_f && (rd_entry.counter >= WT);
    assign bp.pc_pred_f = pred_taken_f ? rd_entry.target : bp.pc_f + PC_WIDTH'(4);

    // ---------------- F/D prediction record ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_valid_q       <= 1'b0;
            rec_index_q       <= '0;
            rec_pred_taken_q  <= 1'b0;
            rec_pred_target_q <= '0;
        end else if (bp.stall_d) begin
            rec_valid_q       <= rec_valid_q;
        end else if (bp.flush_d) begin
            rec_valid_q       <= 1'b0;
        end else begin
            rec_valid_q       <= 1'b1;
            rec_index_q       <= index_f;
            rec_pred_taken_q  <= pred_taken_f;
            rec_pred_target_q <= rd_entry.target;
        end
    end

    // ---------------- Decode resolve / miss ----------------
    assign resolve_d = rec_valid_q && (bp.branch_d != 2'b00) && !bp.stall_d;

    assign bp.predict_miss = resolve_d &&
                             ((rec_pred_taken_q != bp.pc_src_d) ||
                              (rec_pred_taken_q && bp.pc_src_d &&
                               (rec_pred_target_q != bp.pc_branch_d)));

    assign bp.pc_correct_d = bp.pc_src_d ? bp.pc_branch_d : bp.pc_plus4_d;

    // The tag of the Decode branch is recovered from its PC+4; the index
    // comes from the record so it matches the slot used for the lookup.
    assign pc_d           = bp.pc_plus4_d - PC_WIDTH'(4);
    assign unused_pc_d_lo = pc_d[TAG_LSB-1:0];

    branch_target_buffer #(
        .INDEX_BITS (INDEX_BITS)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (index_f),
        .rd_entry  (rd_entry),
        .wr_en     (resolve_d),
        .wr_index  (rec_index_q),
        .wr_tag    (pc_d[PC_WIDTH-1:TAG_LSB]),
        .wr_taken  (bp.pc_src_d),
        .wr_target (bp.pc_branch_d)
    );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam logic [31:0] T   = 32'h0040_0000;
    localparam logic [31:0] B   = 32'h0040_0010;
    localparam logic [31:0] TGT = 32'h0040_0040;
    localparam logic [31:0] A2  = 32'h0040_0110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.PC_WIDTH(32)) bus();

    branch_predictor #(
        .INDEX_BITS (6),
        .PC_WIDTH   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus)
    );

    typedef struct {
        logic [31:0] pc_f;
        logic        stall_d;
        logic        flush_d;
        logic [1:0]  branch_d;
        logic        pc_src_d;
        logic [31:0] pc_branch_d;
        logic [31:0] pc_plus4_d;
        logic [31:0] exp_pred;
        logic        exp_miss;
        logic [31:0] exp_correct;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] pred;
        logic        miss;
        logic [31:0] correct;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check32(input string name, input int id,
                           input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got 0x%08h expected 0x%08h", name, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc_f, input logic stall, input logic flush,
                                input logic [1:0] br, input logic src,
                                input logic [31:0] pcb, input logic [31:0] pp4,
                                input logic [31:0] ep, input logic em, input logic [31:0] ec);
        vec_t v;
        v.pc_f = pc_f; v.stall_d = stall; v.flush_d = flush; v.branch_d = br;
        v.pc_src_d = src; v.pc_branch_d = pcb; v.pc_plus4_d = pp4;
        v.exp_pred = ep; v.exp_miss = em; v.exp_correct = ec;
        return v;
    endfunction

    function automatic vec_t nb(input logic [31:0] pc_f, input logic [31:0] ep);
        return mk(pc_f, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, ep, 1'b0, 32'h0);
    endfunction

    task automatic set_idle(input logic [31:0] pc_f);
        bus.pc_f = pc_f; bus.stall_f = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
        bus.branch_d = 2'b00; bus.pc_src_d = 1'b0; bus.pc_branch_d = '0; bus.pc_plus4_d = '0;
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue the
    // expected combinational outputs for the checker on the falling edge.
    task automatic drive(input vec_t v, input int id);
        exp_t x;
        @(posedge clk);
        #1;
        bus.pc_f = v.pc_f; bus.stall_f = v.stall_d; bus.stall_d = v.stall_d;
        bus.flush_d = v.flush_d; bus.branch_d = v.branch_d; bus.pc_src_d = v.pc_src_d;
        bus.pc_branch_d = v.pc_branch_d; bus.pc_plus4_d = v.pc_plus4_d;
        x.id = id; x.pred = v.exp_pred; x.miss = v.exp_miss; x.correct = v.exp_correct;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check32("pc_pred_f", e.id, bus.pc_pred_f, e.pred);
            check32("predict_miss", e.id, {31'b0, bus.predict_miss}, {31'b0, e.miss});
            if (e.miss)
                check32("pc_correct_d", e.id, bus.pc_correct_d, e.correct);
        end
    end

    initial begin
        // Fetch, install, loop training (2->3->3->2->1->0), aliasing, stall.
        vecs.push_back(nb(T, 32'h0040_0004));                                                   // 0
        vecs.push_back(nb(B, 32'h0040_0014));                                                   // 1
        vecs.push_back(mk(32'h0040_0014, 0, 1, 2'd1, 1, TGT, 32'h0040_0014, 32'h0040_0018, 1, TGT)); // 2
        vecs.push_back(mk(B, 0, 0, 2'd1, 0, 32'h0, 32'h0040_0014, TGT, 0, 32'h0));              // 3
        vecs.push_back(mk(TGT, 0, 0, 2'd1, 1, TGT, 32'h0040_0014, 32'h0040_0044, 0, 32'h0));    // 4
        vecs.push_back(nb(B, TGT));                                                             // 5
        vecs.push_back(mk(TGT, 0, 0, 2'd2, 1, TGT, 32'h0040_0014, 32'h0040_0044, 0, 32'h0));    // 6
        vecs.push_back(nb(B, TGT));                                                             // 7
        vecs.push_back(mk(TGT, 0, 1, 2'd1, 0, TGT, 32'h0040_0014, 32'h0040_0044, 1, 32'h0040_0014)); // 8
        vecs.push_back(nb(B, TGT));                                                             // 9
        vecs.push_back(mk(32'h0040_0014, 0, 1, 2'd1, 0, TGT, 32'h0040_0014, 32'h0040_0018, 1, 32'h0040_0014)); // 10
        vecs.push_back(nb(B, 32'h0040_0014));                                                   // 11
        vecs.push_back(mk(T, 0, 0, 2'd1, 0, TGT, 32'h0040_0014, 32'h0040_0004, 0, 32'h0));      // 12
        vecs.push_back(nb(A2, 32'h0040_0114));                                                  // 13
        vecs.push_back(mk(32'h0040_0114, 0, 1, 2'd1, 1, 32'h0040_0200, 32'h0040_0114, 32'h0040_0118, 1, 32'h0040_0200)); // 14
        vecs.push_back(nb(A2, 32'h0040_0200));                                                  // 15
        vecs.push_back(nb(B, 32'h0040_0014));                                                   // 16
        vecs.push_back(mk(32'h0040_0014, 0, 0, 2'd1, 0, TGT, 32'h0040_0014, 32'h0040_0018, 0, 32'h0)); // 17
        vecs.push_back(nb(A2, 32'h0040_0200));                                                  // 18
        vecs.push_back(mk(32'h0040_0200, 1, 0, 2'd1, 0, 32'h0040_0200, 32'h0040_0114, 32'h0040_0204, 0, 32'h0)); // 19
        vecs.push_back(mk(A2, 1, 1, 2'd1, 0, 32'h0040_0200, 32'h0040_0114, 32'h0040_0200, 0, 32'h0)); // 20
        vecs.push_back(mk(A2, 0, 1, 2'd1, 0, 32'h0040_0200, 32'h0040_0114, 32'h0040_0200, 1, 32'h0040_0114)); // 21
        vecs.push_back(nb(A2, 32'h0040_0114));                                                  // 22

        // Reset state, with a branch presented in Decode.
        set_idle(T);
        bus.branch_d = 2'b01; bus.pc_src_d = 1'b1; bus.pc_branch_d = TGT;
        #12;
        check32("reset_pred", -1, bus.pc_pred_f, 32'h0040_0004);
        check32("reset_miss", -1, {31'b0, bus.predict_miss}, 32'h0);
        set_idle(T);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i], i);

        // Taken branch resolving while reset is asserted mid-cycle.
        drive(mk(A2, 0, 0, 2'd1, 1, 32'h0040_0300, 32'h0040_0114, 32'h0040_0114, 1, 32'h0040_0300), 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midreset_miss", 101, {31'b0, bus.predict_miss}, 32'h0);
        check32("midreset_pred", 101, bus.pc_pred_f, 32'h0040_0114);
        @(posedge clk);
        #1;
        set_idle(B);
        #2;
        rst_n = 1'b1;
        drive(nb(B, 32'h0040_0014), 102);
        drive(nb(A2, 32'h0040_0114), 103);
        drive(nb(T, 32'h0040_0004), 104);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
